// File: rtl/pipe_stage_ctl_if.sv
// Handshake bundle for one pipeline-stage boundary: upstream valid/ready/data,
// downstream valid/ready/data and the occupancy count.
interface pipe_stage_ctl_if #(
  parameter int DW = 134
);
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [1:0]    count_o;

  // Producer/consumer side that drives the stage
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );

  // The stage itself
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_ctl.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a configurable bubble value when empty.
module pipe_stage_ctl #(
  parameter int            DW         = 134,
  parameter logic [DW-1:0] BUBBLE_VAL = {DW{1'b0}},
  parameter bit            SKID       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  pipe_stage_ctl_if.slave    bus
);

  logic          r_m_v;
  logic          r_s_v;
  logic [DW-1:0] r_m_d;
  logic [DW-1:0] r_s_d;

  logic          w_in_ready;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_m_v_nxt;
  logic          w_s_v_nxt;
  logic [DW-1:0] w_m_d_nxt;
  logic [DW-1:0] w_s_d_nxt;

  // With a skid entry, ready comes straight from a flop so upstream timing is
  // isolated; without it, ready looks through to the downstream ready.
  generate
    if (SKID) begin : g_skid
      assign w_in_ready = !r_s_v;
    end else begin : g_no_skid
      assign w_in_ready = !r_m_v | bus.out_ready_i;
    end
  endgenerate

  assign w_in_xfer  = bus.in_valid_i & w_in_ready;
  assign w_out_xfer = r_m_v & bus.out_ready_i;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_m_v_nxt = r_m_v;
    w_m_d_nxt = r_m_d;
    w_s_v_nxt = r_s_v;
    w_s_d_nxt = r_s_d;

    if (flush_i) begin
      w_m_v_nxt = 1'b0;
      w_s_v_nxt = 1'b0;
      w_m_d_nxt = BUBBLE_VAL;
    end else if (w_out_xfer && r_s_v) begin
      w_m_d_nxt = r_s_d;
      if (w_in_xfer) begin
        w_s_d_nxt = bus.in_data_i;
      end else begin
        w_s_v_nxt = 1'b0;
      end
    end else if (w_out_xfer) begin
      if (w_in_xfer) begin
        w_m_v_nxt = 1'b1;
        w_m_d_nxt = bus.in_data_i;
      end else begin
        w_m_v_nxt = 1'b0;
        w_m_d_nxt = BUBBLE_VAL;
      end
    end else if (w_in_xfer && !r_m_v) begin
      w_m_v_nxt = 1'b1;
      w_m_d_nxt = bus.in_data_i;
    end else if (w_in_xfer && SKID) begin
      w_s_v_nxt = 1'b1;
      w_s_d_nxt = bus.in_data_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
      r_m_d <= BUBBLE_VAL;
    end else begin
      r_m_v <= w_m_v_nxt;
      r_s_v <= SKID ? w_s_v_nxt : 1'b0;
      r_m_d <= w_m_d_nxt;
    end
  end

  // NOTE: skid payload is never reset; it is only observable through r_m_d
  // after r_s_v has qualified it, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    r_s_d <= w_s_d_nxt;
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_m_v;
  assign bus.out_data_o  = r_m_d;
  assign bus.count_o     = {1'b0, r_m_v} + {1'b0, r_s_v};

endmodule

// File: tb/tb_pipe_stage_ctl.sv
// Bench for pipe_stage_ctl: one skid instance and one single-register
// instance, checked with directed vectors and a FIFO reference model.
module tb_pipe_stage_ctl;

  localparam int          DW  = 16;
  localparam logic [15:0] BUB = 16'hBEEF;

  logic clk = 1'b0;
  logic rst;
  logic flush1;
  logic flush0;

  always #5 clk = ~clk;

  pipe_stage_ctl_if #(.DW(DW)) bus1 ();
  pipe_stage_ctl_if #(.DW(DW)) bus0 ();

  pipe_stage_ctl #(.DW(DW), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush1),
    .bus     (bus1)
  );

  pipe_stage_ctl #(.DW(DW), .BUBBLE_VAL(BUB), .SKID(1'b0)) u_no_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush0),
    .bus     (bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q1[$];
  logic [15:0] q0[$];

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        fl;
    logic        e_rdy;
    logic        e_v;
    logic [15:0] e_d;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  task automatic model_step(input bit skid, input logic iv, input logic [15:0] d,
                            input logic ordy, input logic fl,
                            input logic a_rdy, input logic a_v,
                            input logic [15:0] a_d, input logic [1:0] a_cnt);
    int          sz;
    logic        e_v;
    logic        e_rdy;
    logic [15:0] e_d;
    string       tag;
    sz    = skid ? q1.size() : q0.size();
    e_v   = (sz != 0);
    e_d   = (sz == 0) ? BUB : (skid ? q1[0] : q0[0]);
    e_rdy = skid ? (sz < 2) : (sz == 0 || ordy);
    tag   = skid ? "skid" : "noskid";
    check({tag, " in_ready"},  {31'd0, a_rdy}, {31'd0, e_rdy});
    check({tag, " out_valid"}, {31'd0, a_v},   {31'd0, e_v});
    check({tag, " out_data"},  {16'd0, a_d},   {16'd0, e_d});
    check({tag, " count"},     {30'd0, a_cnt}, sz);
    if (fl) begin
      if (skid) q1.delete(); else q0.delete();
    end else begin
      if (e_v && ordy) begin
        if (skid) void'(q1.pop_front()); else void'(q0.pop_front());
      end
      if (iv && e_rdy) begin
        if (skid) q1.push_back(d); else q0.push_back(d);
      end
    end
  endtask

  task automatic drive1(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    bus1.in_valid_i  = iv;
    bus1.in_data_i   = d;
    bus1.out_ready_i = ordy;
    flush1           = fl;
  endtask

  task automatic drive0(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    bus0.in_valid_i  = iv;
    bus0.in_data_i   = d;
    bus0.out_ready_i = ordy;
    flush0           = fl;
  endtask

  task automatic check_empty(input string name);
    check({name, " s1 valid"}, {31'd0, bus1.out_valid_o}, 32'd0);
    check({name, " s1 data"},  {16'd0, bus1.out_data_o},  {16'd0, BUB});
    check({name, " s1 count"}, {30'd0, bus1.count_o},     32'd0);
    check({name, " s1 ready"}, {31'd0, bus1.in_ready_o},  32'd1);
  endtask

  task automatic step_both(input logic iv1, input logic [15:0] d1, input logic or1, input logic fl1,
                           input logic iv0, input logic [15:0] d0, input logic or0, input logic fl0);
    @(negedge clk);
    drive1(iv1, d1, or1, fl1);
    drive0(iv0, d0, or0, fl0);
    #1;
    model_step(1'b1, iv1, d1, or1, fl1, bus1.in_ready_o, bus1.out_valid_o, bus1.out_data_o, bus1.count_o);
    model_step(1'b0, iv0, d0, or0, fl0, bus0.in_ready_o, bus0.out_valid_o, bus0.out_data_o, bus0.count_o);
  endtask

  initial begin
    rst = 1'b1;
    drive1(1'b0, 16'h0, 1'b0, 1'b0);
    drive0(1'b0, 16'h0, 1'b0, 1'b0);

    // Reset held for two cycles under random inputs
    repeat (2) begin
      @(negedge clk);
      drive1(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      drive0(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    rst = 1'b0;
    drive1(1'b0, 16'h0, 1'b0, 1'b0);
    drive0(1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    check_empty("reset");
    check("reset s0 valid", {31'd0, bus0.out_valid_o}, 32'd0);
    check("reset s0 data",  {16'd0, bus0.out_data_o},  {16'd0, BUB});
    check("reset s0 count", {30'd0, bus0.count_o},     32'd0);
    check("reset s0 ready", {31'd0, bus0.in_ready_o},  32'd1);

    // Back-to-back streaming 0x1..0x10, then one idle cycle to drain
    for (int i = 1; i <= 16; i++) begin
      step_both(1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 16'(i), 1'b1, 1'b0);
      if (i > 1) begin
        check("stream s1 data", {16'd0, bus1.out_data_o}, i - 1);
        check("stream s0 data", {16'd0, bus0.out_data_o}, i - 1);
      end
    end
    step_both(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step_both(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Directed skid corner cases: {iv, d, ordy, fl} -> state after the edge
    vecs.push_back('{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 2'd1});
    vecs.push_back('{1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2});
    vecs.push_back('{1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2});
    vecs.push_back('{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 2'd1});
    vecs.push_back('{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 2'd1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, BUB,      2'd0});
    vecs.push_back('{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 2'd1});
    vecs.push_back('{1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2});
    vecs.push_back('{1'b1, 16'h000C, 1'b0, 1'b1, 1'b1, 1'b0, BUB,      2'd0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, BUB,      2'd0});
    vecs.push_back('{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 2'd1});
    vecs.push_back('{1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2});
    vecs.push_back('{1'b1, 16'h000D, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 2'd1});
    vecs.push_back('{1'b1, 16'h000D, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000B, 2'd2});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000D, 2'd1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, BUB,      2'd0});
    vecs.push_back('{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 2'd1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, BUB,      2'd0});

    @(negedge clk);
    drive0(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive1(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i),  {31'd0, bus1.in_ready_o},  {31'd0, vecs[i].e_rdy});
      check($sformatf("vec%0d out_valid", i), {31'd0, bus1.out_valid_o}, {31'd0, vecs[i].e_v});
      check($sformatf("vec%0d out_data", i),  {16'd0, bus1.out_data_o},  {16'd0, vecs[i].e_d});
      check($sformatf("vec%0d count", i),     {30'd0, bus1.count_o},     {30'd0, vecs[i].e_cnt});
    end

    // Reset while full must leave no residual skid payload behind
    drive1(1'b1, 16'h00A1, 1'b0, 1'b0);
    @(negedge clk);
    drive1(1'b1, 16'h00B2, 1'b0, 1'b0);
    @(negedge clk);
    check("full before reset count", {30'd0, bus1.count_o}, 32'd2);
    rst = 1'b1;
    drive1(1'b1, 16'h00C3, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive1(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    check_empty("rst full");
    drive1(1'b1, 16'h00E4, 1'b0, 1'b0);
    @(negedge clk);
    drive1(1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    check("post rst data",  {16'd0, bus1.out_data_o}, 32'h00E4);
    check("post rst count", {30'd0, bus1.count_o},    32'd1);
    @(negedge clk);
    drive1(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    check_empty("post rst drain");

    // Random traffic on both instances against the FIFO model
    for (int i = 0; i < 1000; i++) begin
      step_both(1'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0),
                1'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0));
      check("noskid ready rule", {31'd0, bus0.in_ready_o},
            {31'd0, (!bus0.out_valid_o) | bus0.out_ready_i});
      if (bus1.count_o == 2'd2)
        check("skid implies main", {31'd0, bus1.out_valid_o}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
